reg_write_ctrl: RTL
===================

# reg_write_ctrl

Upstream write controller for the pipeline register stage. Accepts write requests over a valid/ready handshake and drives the register's `sel`/`wr`/`wdata` inputs with a single-cycle write pulse. It then reads the value back on `rdata` the following cycle to confirm it. Mismatches are retried a bounded number of times, then reported as an error and counted.

## Interface
- `DATA_WIDTH`, 32, width of request data, `wdata`, `rdata`
- `MAX_RETRY`, 3, extra write attempts after a failed verify (0 = no retry); range 0..15
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge
- `in_valid`  in  1  request present
- `in_ready`  out  1  controller can accept a request
- `in_data`  in  DATA_WIDTH  value to write
- `sel`  out  1  register select
- `wr`  out  1  register write strobe
- `wdata`  out  DATA_WIDTH  value presented to register
- `rdata`  in  DATA_WIDTH  register read-back
- `busy`  out  1  request in flight (state != IDLE)
- `done`  out  1  one-cycle pulse: write verified
- `err`  out  1  one-cycle pulse: retries exhausted
- `err_count`  out  8  saturating count of `err` pulses

## Operation
- Register contract: when `sel`=1 and `wr`=1 at an edge, `rdata` equals `wdata` for the whole next cycle.
- States: IDLE, WRITE, VERIFY. Encoding is 2-bit, IDLE=0.
- IDLE:
  - `in_ready`=1, `sel`=0, `wr`=0.
  - On `in_valid`=1, latch `in_data` into the hold register, clear the retry counter, go to WRITE.
- WRITE:
  - `sel`=1, `wr`=1, `wdata`=hold. Go to VERIFY unconditionally.
- VERIFY:
  - `sel`=1, `wr`=0.
  - If `rdata`==hold: set `done` next cycle, go to IDLE.
  - Else if retry < `MAX_RETRY`: increment retry, go to WRITE.
  - Else: set `err` next cycle, increment `err_count` (saturate at 255), go to IDLE.
- `in_ready`=0 in WRITE and VERIFY. `in_data` changes while not ready are ignored.
- `wdata` always shows the hold register, including in IDLE; reset value 0.
- The hold register is unchanged during retries.
- `done` and `err` are registered and never high together.

## Timing
- Reset values (cycle after `reset` sampled low): state IDLE, `in_ready`=1, `sel`=0, `wr`=0, `wdata`=0, `busy`=0, `done`=0, `err`=0, `err_count`=0, retry=0.
- Reset mid-operation abandons the request: no `done`/`err` pulse, no `err_count` change.
- Accept at edge k (`in_valid`&`in_ready`):
  - WRITE during cycle k+1 (`wr`=1).
  - VERIFY during cycle k+2.
  - `done` high during cycle k+3 (also IDLE, `in_ready`=1).
- Best-case throughput is one request per 3 cycles. A request may be accepted in the same cycle `done`/`err` is high.
- Each retry adds 2 cycles. Worst-case request latency is 3 + 2·`MAX_RETRY` cycles to the `done`/`err` pulse.
- `wr` is never high for two consecutive cycles. `sel` stays high from WRITE through the final VERIFY.
- `err_count` updates on the same edge that sets `err`.

## Structure
- Shared package `reg_wr_pkg` holds:
  - state encoding localparams (`ST_IDLE`, `ST_WRITE`, `ST_VERIFY`)
  - default `DATA_WIDTH`
  - `ERR_CNT_W`=8
- Single flat module, no sub-modules: the FSM, hold register, retry counter and error counter fit in about 150 lines.
- The bench instantiates the existing pipeline register as the downstream load. It adds a fault-injection wrapper that can force `rdata` mismatches.

## Test plan
- Reset held low 2 cycles with `in_valid`=1 → all outputs at reset values, no accept. Release → `in_ready`=1.
- Single request `in_data`=32'h0000abcd → `wr` pulse 1 cycle with `wdata`=32'habcd, `done` at k+3, `err_count`=0.
- Back-to-back requests 32'h1234, 32'hcdef, 32'hbeef with `in_valid` held high → accepts 3 cycles apart, three `done` pulses, register ends at 32'hbeef.
- Force one `rdata` mismatch on 32'h2424 → exactly 2 `wr` pulses, `done` at k+5, no `err`.
- Force permanent mismatch with `MAX_RETRY`=3 → 4 `wr` pulses, `err` at k+9, `err_count`=1; repeat 256 times → `err_count` saturates at 255.
- Assert `reset` low during VERIFY → next cycle IDLE, `sel`=0, no `done`/`err`, `err_count` unchanged.

Source files
------------

// File: rtl/reg_wr_pkg.sv
// reg_wr_pkg: shared state encoding and widths for the register write controller.
package reg_wr_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int ERR_CNT_W          = 8;
    localparam int RETRY_W            = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;
endpackage

// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: writes each accepted request into the register, verifies the read-back,
// retries mismatches up to MAX_RETRY times and counts unrecoverable failures.
module reg_write_ctrl
    import reg_wr_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  sel,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_count
);
    localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        retry_d   = retry_q;
        err_cnt_d = err_cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    retry_d = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_VERIFY;
            ST_VERIFY: begin
                if (rdata == hold_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = ST_WRITE;
                end else begin
                    err_d     = 1'b1;
                    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            retry_q   <= '0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            retry_q   <= retry_d;
            err_cnt_q <= err_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Outputs decode straight from the state flop, so none depends on live inputs.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign sel       = busy;
    assign wr        = (state_q == ST_WRITE);
    assign wdata     = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;
endmodule
